// File: rtl/fetch_queue_unit_pkg.sv
// Shared types for the fetch queue unit: queued fetch entry and fetch FSM states.
// The entry struct is sized by the package defaults; the top's WIDTH/INDEX must match them.
package fetch_queue_unit_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_INDEX = 8;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] instr;
        logic [DEFAULT_WIDTH-1:0] pc;
        logic [DEFAULT_WIDTH-1:0] pred_pc;
        logic [DEFAULT_INDEX-1:0] ghr_index;
        logic [1:0]               pht_state;
        logic                     redirect;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_FETCH,
        ST_STALL
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Head-of-queue handshake bus from the fetch unit to decode.
interface fetch_queue_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned INDEX = 8
);
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outInstr;
    logic [WIDTH-1:0] outPC;
    logic [WIDTH-1:0] outPredPC;
    logic [INDEX-1:0] outGHRIndex;
    logic [1:0]       outPHTState;
    logic             outRedirect;

    modport master (
        output outValid, outInstr, outPC, outPredPC, outGHRIndex, outPHTState, outRedirect,
        input  outReady
    );

    modport slave (
        input  outValid, outInstr, outPC, outPredPC, outGHRIndex, outPHTState, outRedirect,
        output outReady
    );
endinterface

// File: rtl/fetch_queue_unit_fetch_queue.sv
// Circular buffer of fetch entries with enqueue, dequeue and single-cycle clear.
// Head is read combinationally from storage; occupancy is guarded against over/underflow.
module fetch_queue
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     enq,
    input  logic                     deq,
    input  fetch_entry_t             enq_entry,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             deq_ok;
    logic             enq_ok;

    // A push into a full queue is only legal when the head leaves on the same edge.
    always_comb begin
        deq_ok = deq && (occupancy != '0);
        enq_ok = enq && ((occupancy != CNT_W'(DEPTH)) || deq_ok);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (enq_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            occupancy <= occupancy + CNT_W'(enq_ok) - CNT_W'(deq_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (enq_ok && !rst && !clear) mem[wr_ptr] <= enq_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: next-PC selection (mispredict > JAL > BTB/gshare > sequential),
// fetch/stall FSM, and the instruction queue feeding decode.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned     WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     INDEX    = DEFAULT_INDEX,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   globalReset,
    input  logic                   mispredict,
    input  logic [WIDTH-1:0]       correctTarget,
    input  logic                   isJAL,
    input  logic [WIDTH-1:0]       validAddress,
    input  logic                   btbHit,
    input  logic [WIDTH-1:0]       btbTarget,
    input  logic [1:0]             phtState,
    input  logic [INDEX-1:0]       ghrIndex,
    output logic [WIDTH-1:0]       fetchPC,
    input  logic [WIDTH-1:0]       imemData,
    fetch_queue_unit_if.master     head_bus,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state;
    fetch_state_t     state_next;
    fetch_entry_t     enq_entry;
    fetch_entry_t     head;
    logic             redirect;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_pc;
    logic             head_valid;
    logic             head_fire;
    logic             can_enq;
    logic             enq;

    always_comb begin
        redirect   = mispredict || isJAL;
        pred_taken = btbHit && phtState[1];
        pred_pc    = pred_taken ? btbTarget : fetchPC + WIDTH'(4);
        head_valid = (occupancy != '0);
        head_fire  = head_valid && head_bus.outReady;
        can_enq    = (occupancy < CNT_W'(DEPTH)) || head_fire;
    end

    // Next-state and enqueue decision; any redirect returns to FETCH.
    always_comb begin
        state_next = state;
        enq        = 1'b0;
        if (redirect) begin
            state_next = ST_FETCH;
        end else begin
            enq        = can_enq || (state == ST_RESET);
            state_next = can_enq ? ST_FETCH : ST_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (globalReset) state <= ST_RESET;
        else             state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (globalReset)     fetchPC <= RESET_PC;
        else if (mispredict) fetchPC <= correctTarget;
        else if (isJAL)      fetchPC <= validAddress;
        else if (enq)        fetchPC <= pred_pc;
    end

    always_comb begin
        enq_entry           = '0;
        enq_entry.instr     = DEFAULT_WIDTH'(imemData);
        enq_entry.pc        = DEFAULT_WIDTH'(fetchPC);
        enq_entry.pred_pc   = DEFAULT_WIDTH'(pred_pc);
        enq_entry.ghr_index = DEFAULT_INDEX'(ghrIndex);
        enq_entry.pht_state = phtState;
        enq_entry.redirect  = pred_taken;
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (globalReset),
        .clear     (redirect),
        .enq       (enq),
        .deq       (head_fire && !redirect),
        .enq_entry (enq_entry),
        .head      (head),
        .occupancy (occupancy)
    );

    always_comb begin
        head_bus.outValid    = head_valid;
        head_bus.outInstr    = WIDTH'(head.instr);
        head_bus.outPC       = WIDTH'(head.pc);
        head_bus.outPredPC   = WIDTH'(head.pred_pc);
        head_bus.outGHRIndex = INDEX'(head.ghr_index);
        head_bus.outPHTState = head.pht_state;
        head_bus.outRedirect = head.redirect;
    end

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameters: WIDTH=32 (address/instruction bits); DEPTH=4 (queue entries, power of 2, >=2); INDEX=8 (GHR index bits); RESET_PC=32'h0 (fetch start address).
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 globalReset  in  1  synchronous, active-high reset.
REQ-004 mispredict  in  1  commit-stage correction; highest priority.
REQ-005 correctTarget  in  WIDTH  redirect address for mispredict.
REQ-006 isJAL  in  1  rename-stage JAL redirect.
REQ-007 validAddress  in  WIDTH  JAL target.
REQ-008 btbHit  in  1  valid BTB hit for current fetchPC.
REQ-009 btbTarget  in  WIDTH  BTB predicted target.
REQ-010 phtState  in  2  gshare counter for current fetchPC; bit1 = predict taken.
REQ-011 ghrIndex  in  INDEX  gshare index for current fetchPC.
REQ-012 fetchPC  out  WIDTH  current fetch address to imem/BTB/gshare.
REQ-013 imemData  in  WIDTH  combinational imem read data for fetchPC.
REQ-014 outReady  in  1  decode accepts head entry.
REQ-015 outValid  out  1  head entry valid.
REQ-016 outInstr, outPC, outPredPC  out  WIDTH each  head instruction, its PC, predicted next PC.
REQ-017 outGHRIndex  out  INDEX; outPHTState  out  2; outRedirect  out  1 (head was predicted-taken).
REQ-018 occupancy  out  clog2(DEPTH)+1  live entry count.

Function
REQ-019 Redirect priority: mispredict > isJAL > (btbHit & phtState[1]) > sequential fetchPC+4.
REQ-020 mispredict: queue cleared, fetchPC<=correctTarget, no enqueue, any dequeue ignored, same edge.
REQ-021 isJAL (no mispredict): queue cleared, fetchPC<=validAddress, no enqueue.
REQ-022 canEnq = (occupancy<DEPTH) | (outValid & outReady); no redirect and canEnq -> enqueue {imemData, fetchPC, predPC, ghrIndex, phtState, predTaken}.
REQ-023 predTaken=btbHit&phtState[1]; predPC=predTaken?btbTarget:fetchPC+4; fetchPC<=predPC on enqueue.
REQ-024 Not canEnq and no redirect: fetchPC holds (STALL); BTB/PHT prediction for held PC re-evaluated next cycle.
REQ-025 Enqueue-to-visible latency 1 cycle; head fields driven combinationally from storage; outValid=(occupancy!=0).
REQ-026 Dequeue when outValid & outReady; simultaneous enq+deq on full or non-empty queue leaves occupancy unchanged.
REQ-027 Read/write pointers log2(DEPTH) bits, wrap modulo DEPTH; occupancy never exceeds DEPTH nor underflows.
REQ-028 FSM states: RESET (first cycle after reset released: fetchPC=RESET_PC, enqueue enabled), FETCH (canEnq), STALL (full, no dequeue); FETCH<->STALL on canEnq; any redirect -> FETCH.
REQ-029 fetchPC+4 wraps modulo 2^WIDTH.

Reset
REQ-030 globalReset dominates all inputs: fetchPC<=RESET_PC, pointers<=0, occupancy<=0, FSM<=RESET, outValid=0; entry storage need not be cleared.
REQ-031 Reset asserted mid-stall or mid-redirect discards all queued entries; no enqueue that cycle.

Structure
REQ-032 Shared package: fetch entry struct (instr, pc, predPC, ghrIndex, phtState, redirect), FSM enum, default WIDTH/INDEX.
REQ-033 One sub-module fetch_queue (parametrised DEPTH circular buffer with enq/deq/clear); PC select and FSM in top.

Verification
REQ-034 Reset, outReady=1, no hits, imemData=addr -> outPC 0,4,8,12 on consecutive cycles, outRedirect=0.
REQ-035 outReady=0 DEPTH=4 -> occupancy 4, fetchPC held at 16; outReady=1 -> occupancy stays 4 while streaming, fetchPC advances.
REQ-036 At fetchPC=8 btbHit=1, phtState=2'b10, btbTarget=0x100 -> entry PC 8 predPC 0x100 outRedirect=1, next fetchPC=0x100; phtState=2'b01 -> predPC 12.
REQ-037 Queue 3 entries, mispredict=1 with isJAL=1, correctTarget=0x200, validAddress=0x300 -> next cycle occupancy 0, fetchPC=0x200.
REQ-038 globalReset asserted while full and mispredict=1 -> occupancy 0, fetchPC=RESET_PC, outValid=0.
